// File: rtl/regslv_onrw_array.sv
// Register-slave leaf with ENTRY_NUM registers, each with its own read side effect, write mode and hw pulse port.
// Define REGSLV_WR_LOCK_EN to add a write-lock register just past the last entry.
`timescale 1ns/1ps
module regslv_onrw_array #(
  parameter int                             ADDR_WIDTH   = 64,
  parameter int                             DATA_WIDTH   = 32,
  parameter int                             ENTRY_NUM    = 4,
  parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR    = '0,
  parameter logic [2*ENTRY_NUM-1:0]         ONREAD_MODE  = '0,
  parameter logic [2*ENTRY_NUM-1:0]         ONWRITE_MODE = '0,
  parameter logic [ENTRY_NUM*DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                            fsm_clk,
  input  logic                            fsm_rst,
  input  logic                            req_vld,
  input  logic                            wr_en,
  input  logic                            rd_en,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            ack_vld,
  output logic [DATA_WIDTH-1:0]           rd_data,
  input  logic [ENTRY_NUM*DATA_WIDTH-1:0] hw_next_value,
  input  logic [ENTRY_NUM-1:0]            hw_pulse,
  output logic [ENTRY_NUM*DATA_WIDTH-1:0] curr_value,
  input  logic                            global_sync_reset_in,
  output logic                            global_sync_reset_out
);

  // DATA_WIDTH/8 is expected to be a power of two so the word index is a plain shift.
  localparam int BYTE_NUM   = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 0;
  localparam int IDX_W      = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, ACK} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    wr_en_q, rd_en_q;
  logic                    hit_q;
  logic [IDX_W-1:0]        idx_q;
  logic [ADDR_WIDTH-1:0]   offset, word;
  logic                    in_range, aligned, dec_hit;
  logic                    sw_wr, sw_rd, wr_locked;
  logic [DATA_WIDTH-1:0]   entry_val [2**IDX_W];

  assign offset   = addr_q - BASE_ADDR;
  assign word     = offset >> BYTE_SHIFT;
  assign in_range = (addr_q >= BASE_ADDR);
  assign aligned  = ((offset & ADDR_WIDTH'(BYTE_NUM - 1)) == '0);
  assign dec_hit  = in_range && aligned && (word < ADDR_WIDTH'(ENTRY_NUM));

  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_vld) state_nxt = DECODE;
      DECODE:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (global_sync_reset_in) state_nxt = IDLE;
  end

  // Request fields are captured only in IDLE so a strobe mid-transaction is ignored.
  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (state == IDLE && req_vld) begin
        addr_q    <= addr;
        wr_data_q <= wr_data;
        wr_en_q   <= wr_en;
        rd_en_q   <= rd_en;
      end
      if (state == DECODE) begin
        hit_q <= dec_hit;
        idx_q <= word[IDX_W-1:0];
      end
    end
  end

  assign ack_vld = (state == ACK);
  assign sw_wr   = ack_vld && wr_en_q;
  assign sw_rd   = ack_vld && rd_en_q && !wr_en_q;

`ifdef REGSLV_WR_LOCK_EN
  logic lock_q, lock_hit_q, dec_lock_hit;

  assign dec_lock_hit = in_range && aligned && (word == ADDR_WIDTH'(ENTRY_NUM));

  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      lock_q     <= 1'b0;
      lock_hit_q <= 1'b0;
    end else begin
      if (state == DECODE) lock_hit_q <= dec_lock_hit;
      if (global_sync_reset_in)                        lock_q <= 1'b0;
      else if (sw_wr && lock_hit_q && wr_data_q[0])    lock_q <= 1'b1;
    end
  end

  assign wr_locked = lock_q;
`else
  assign wr_locked = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (sw_rd && hit_q) rd_data = entry_val[idx_q];
`ifdef REGSLV_WR_LOCK_EN
    if (sw_rd && lock_hit_q) rd_data = {{(DATA_WIDTH-1){1'b0}}, lock_q};
`endif
  end

  // Per entry priority: sync reset, then hw pulse, then software write or read side effect.
  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_entry
    if (i < ENTRY_NUM) begin : g_reg
      localparam logic [1:0]            RD_MODE = ONREAD_MODE[2*i +: 2];
      localparam logic [1:0]            WR_MODE = ONWRITE_MODE[2*i +: 2];
      localparam logic [DATA_WIDTH-1:0] RST_VAL = RESET_VAL[DATA_WIDTH*i +: DATA_WIDTH];

      logic [DATA_WIDTH-1:0] value;
      logic                  sel;

      assign sel = hit_q && (idx_q == IDX_W'(i));

      always_ff @(posedge fsm_clk or posedge fsm_rst) begin
        if (fsm_rst) begin
          value <= RST_VAL;
        end else if (global_sync_reset_in) begin
          value <= RST_VAL;
        end else if (hw_pulse[i]) begin
          value <= hw_next_value[DATA_WIDTH*i +: DATA_WIDTH];
        end else if (sel && sw_wr && !wr_locked) begin
          case (WR_MODE)
            2'd0:    value <= wr_data_q;
            2'd1:    value <= value & ~wr_data_q;
            2'd2:    value <= value | wr_data_q;
            default: value <= value;
          endcase
        end else if (sel && sw_rd) begin
          case (RD_MODE)
            2'd1:    value <= '0;
            2'd2:    value <= '1;
            default: value <= value;
          endcase
        end
      end

      assign entry_val[i] = value;
      assign curr_value[DATA_WIDTH*i +: DATA_WIDTH] = value;
    end else begin : g_pad
      assign entry_val[i] = '0;
    end
  end

  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) global_sync_reset_out <= 1'b0;
    else         global_sync_reset_out <= global_sync_reset_in;
  end

endmodule

// File: tb/tb_regslv_onrw_array.sv
// Self-checking bench for regslv_onrw_array: six entries covering every read/write mode, with a read-data scoreboard.
// Lock checks follow REGSLV_WR_LOCK_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_regslv_onrw_array;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EN = 6;
  localparam logic [AW-1:0] BASE = 32'h0000_0100;

  // Entries: 0 NA/W, 1 RCLR/W, 2 RSET/W, 3 NA/W1C, 4 NA/W1S, 5 NA/RO
  localparam logic [2*EN-1:0]  RD_MODES = {2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0};
  localparam logic [2*EN-1:0]  WR_MODES = {2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [EN*DW-1:0] RST_VALS = {32'hDEAD_BEEF, 32'h0000_0000, 32'hFF00_FF00,
                                           32'h3333_3333, 32'h2222_2222, 32'h0000_0000};
  localparam logic [DW-1:0] RST_REF [EN] = '{32'h0000_0000, 32'h2222_2222, 32'h3333_3333,
                                             32'hFF00_FF00, 32'h0000_0000, 32'hDEAD_BEEF};
  localparam int RMODE [EN] = '{0, 1, 2, 0, 0, 0};
  localparam int WMODE [EN] = '{0, 0, 0, 1, 2, 3};

`ifdef REGSLV_WR_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_vld = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            ack_vld;
  logic [DW-1:0]   rd_data;
  logic [EN*DW-1:0] hw_next_value = '0;
  logic [EN-1:0]   hw_pulse = '0;
  logic [EN*DW-1:0] curr_value;
  logic            gsr_in = 1'b0;
  logic            gsr_out;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  typedef struct {
    logic [DW-1:0] rd;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          popped;
  logic [DW-1:0] mdl [EN];
  logic          mdl_lock = 1'b0;

  regslv_onrw_array #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .ENTRY_NUM    (EN),
    .BASE_ADDR    (BASE),
    .ONREAD_MODE  (RD_MODES),
    .ONWRITE_MODE (WR_MODES),
    .RESET_VAL    (RST_VALS)
  ) dut (
    .fsm_clk               (clk),
    .fsm_rst               (rst),
    .req_vld               (req_vld),
    .wr_en                 (wr_en),
    .rd_en                 (rd_en),
    .addr                  (addr),
    .wr_data               (wr_data),
    .ack_vld               (ack_vld),
    .rd_data               (rd_data),
    .hw_next_value         (hw_next_value),
    .hw_pulse              (hw_pulse),
    .curr_value            (curr_value),
    .global_sync_reset_in  (gsr_in),
    .global_sync_reset_out (gsr_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every ack pops one scoreboard entry; rd_data must be zero outside ack cycles.
  always @(negedge clk) begin
    if (ack_vld) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_ack", {31'b0, ack_vld}, 32'd0);
      end else begin
        popped = sb.pop_front();
        checkOutput("rd_data", rd_data, popped.rd);
        checkOutput("ack_latency", 32'(cycle - popped.cyc), 32'd2);
      end
    end else begin
      checkOutput("rd_data_idle", rd_data, 32'd0);
    end
  end

  task automatic resetModel();
    for (int i = 0; i < EN; i++) mdl[i] = RST_REF[i];
    mdl_lock = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    #1;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("ack_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Updates the model, pushes the expected rd_data, then runs one bus transaction with an optional hw pulse on the ACK cycle.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [EN-1:0] hw_mask, input logic [DW-1:0] hw_val);
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] off;
    logic          ok, hit, lock_hit;
    int            idx;
    exp_rd   = '0;
    off      = a - BASE;
    ok       = (a >= BASE) && (off[1:0] == 2'b00);
    hit      = ok && (off[AW-1:2] < (AW-2)'(EN));
    lock_hit = LOCK_BUILD && ok && (off[AW-1:2] == (AW-2)'(EN));
    idx      = hit ? int'(off[AW-1:2]) : 0;
    if (wr) begin
      if (hit && !mdl_lock) begin
        case (WMODE[idx])
          0:       mdl[idx] = d;
          1:       mdl[idx] = mdl[idx] & ~d;
          2:       mdl[idx] = mdl[idx] | d;
          default: ;
        endcase
      end
      if (lock_hit && d[0]) mdl_lock = 1'b1;
    end else if (rd) begin
      if (hit) begin
        exp_rd = mdl[idx];
        case (RMODE[idx])
          1:       mdl[idx] = '0;
          2:       mdl[idx] = '1;
          default: ;
        endcase
      end
      if (lock_hit) exp_rd = {31'b0, mdl_lock};
    end
    for (int i = 0; i < EN; i++) if (hw_mask[i]) mdl[i] = hw_val;

    @(negedge clk);
    req_vld = 1'b1; wr_en = wr; rd_en = rd; addr = a; wr_data = d;
    sb.push_back('{rd: exp_rd, cyc: cycle});
    @(negedge clk);
    req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    hw_pulse = hw_mask;
    hw_next_value = {EN{hw_val}};
    @(negedge clk);
    hw_pulse = '0;
    waitDrain();
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(1'b1, 1'b0, a, d, '0, '0);
  endtask

  task automatic doRead(input logic [AW-1:0] a);
    applyStimulus(1'b0, 1'b1, a, '0, '0, '0);
  endtask

  task automatic checkEntry(input int i, input logic [DW-1:0] exp);
    checkOutput($sformatf("entry%0d", i), curr_value[DW*i +: DW], exp);
  endtask

  task automatic checkModel(input string tag);
    for (int i = 0; i < EN; i++)
      checkOutput($sformatf("%s_entry%0d", tag, i), curr_value[DW*i +: DW], mdl[i]);
  endtask

  initial begin
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", {31'b0, ack_vld}, 32'd0);
    checkOutput("rst_gsr_out", {31'b0, gsr_out}, 32'd0);
    for (int i = 0; i < EN; i++) checkEntry(i, RST_REF[i]);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      doWrite(BASE + AW'(4*i), 32'h1234_5678);
      checkEntry(i, 32'h1234_5678);
    end
    for (int i = 0; i < 3; i++) doRead(BASE + AW'(4*i));
    checkEntry(0, 32'h1234_5678);
    checkEntry(1, 32'h0000_0000);
    checkEntry(2, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      doWrite(BASE + AW'(4*i), 32'hFFFF_FFFF);
      checkEntry(i, 32'hFFFF_FFFF);
    end

    doWrite(BASE + 32'd12, 32'h0F00_0F00);
    checkEntry(3, 32'hF000_F000);
    doWrite(BASE + 32'd16, 32'h0000_0011);
    checkEntry(4, 32'h0000_0011);
    doWrite(BASE + 32'd20, 32'h0000_0000);
    checkEntry(5, 32'hDEAD_BEEF);
    doRead(BASE + 32'd20);
    doRead(BASE + 32'd12);
    checkModel("modes");

    // hw pulse wins over the read side effect and over a software write on the same edge
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, '0, 6'b000010, 32'hA5A5_A5A5);
    checkEntry(1, 32'hA5A5_A5A5);
    applyStimulus(1'b1, 1'b0, BASE, 32'h0000_0055, 6'b000001, 32'h0BAD_F00D);
    checkEntry(0, 32'h0BAD_F00D);

    doRead(BASE + 32'd2);
    doRead(BASE - 32'd4);
    doRead(BASE + 32'd28);
    doWrite(BASE + 32'd2, 32'hFFFF_FFFF);
    doWrite(BASE + 32'd28, 32'hFFFF_FFFF);
    checkModel("miss");
    checkEntry(0, 32'h0BAD_F00D);

    applyStimulus(1'b1, 1'b1, BASE + 32'd8, 32'h0000_FFFF, '0, '0);
    checkEntry(2, 32'h0000_FFFF);
    applyStimulus(1'b0, 1'b0, BASE + 32'd4, 32'h0000_0000, '0, '0);
    checkEntry(1, 32'hA5A5_A5A5);

    // A second strobe during DECODE must not be latched or acked
    @(negedge clk);
    req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = BASE + 32'd20;
    sb.push_back('{rd: mdl[5], cyc: cycle});
    @(negedge clk);
    req_vld = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr = BASE; wr_data = 32'hCAFE_0000;
    @(negedge clk);
    req_vld = 1'b0; wr_en = 1'b0;
    waitDrain();
    repeat (3) @(negedge clk);
    checkEntry(0, 32'h0BAD_F00D);

    // Sync reset during DECODE aborts the transfer
    @(negedge clk);
    req_vld = 1'b1; wr_en = 1'b1; addr = BASE; wr_data = 32'h7777_7777;
    @(negedge clk);
    req_vld = 1'b0; wr_en = 1'b0; gsr_in = 1'b1;
    checkOutput("gsr_out_before", {31'b0, gsr_out}, 32'd0);
    @(negedge clk);
    gsr_in = 1'b0;
    checkOutput("gsr_out_high", {31'b0, gsr_out}, 32'd1);
    resetModel();
    for (int i = 0; i < EN; i++) checkEntry(i, RST_REF[i]);
    @(negedge clk);
    checkOutput("gsr_out_low", {31'b0, gsr_out}, 32'd0);
    repeat (3) @(negedge clk);
    checkEntry(0, 32'h0000_0000);

    // Lock register address: lock in the lock build, a plain miss otherwise
    doWrite(BASE + 32'd24, 32'h0000_0001);
    doWrite(BASE, 32'h0000_0001);
    doRead(BASE + 32'd24);
`ifdef REGSLV_WR_LOCK_EN
    checkEntry(0, 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, '0, 6'b000100, 32'h0000_0042);
    checkEntry(2, 32'h0000_0042);
    @(negedge clk); gsr_in = 1'b1;
    @(negedge clk); gsr_in = 1'b0;
    resetModel();
    doWrite(BASE, 32'h0000_0009);
    checkEntry(0, 32'h0000_0009);
`else
    checkEntry(0, 32'h0000_0001);
`endif
    checkModel("lock");

    // Async reset mid-transaction: no ack, everything back to reset
    @(negedge clk);
    req_vld = 1'b1; wr_en = 1'b1; addr = BASE + 32'd16; wr_data = 32'h0000_0F0F;
    @(negedge clk);
    req_vld = 1'b0; wr_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    repeat (4) @(negedge clk);
    for (int i = 0; i < EN; i++) checkEntry(i, RST_REF[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
